fp_addsub_sched: RTL and testbench
==================================

# fp_addsub_sched

Sequencer and two-port round-robin arbiter for the shared combinational single-precision add/subtract unit. It accepts operand pairs from two requesters over valid/ready handshakes and registers the operands and operation onto the datapath inputs. It holds them for a programmable settle time, then captures the datapath result and returns it with the requester ID over a valid/ready response channel. It sits between the issuing logic and the floating-point add/sub datapath, which it drives exclusively.

## Interface
- SETTLE, default 2: cycles operands are held on the datapath before the result is captured; legal range 1..15.

- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset is asynchronous and active-low
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req0_op  in  1  0 = A+B, 1 = A−B
- req0_a, req0_b  in  32  IEEE-754 single operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
- dp_a, dp_b  out  32  registered operands to the datapath
- dp_op  out  1  registered operation select to the datapath
- dp_cin  out  1  datapath carry-in; constant 0
- dp_fout  in  32  datapath result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  32  captured result
- rsp_id  out  1  requester that issued the operation
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant goes to the only valid requester.
  - If both requesters are valid, grant goes to the one not equal to last_id. last_id resets to 1, so requester 0 wins the first tie.
  - reqN_ready = (state==IDLE) & granted & reqN_valid & rst_n. The ready is combinational and never high for both requesters.
- Accept happens on reqN_valid & reqN_ready. At that edge:
  - dp_a, dp_b and dp_op are loaded from the accepted requester.
  - The ID is loaded into rsp_id and last_id.
  - cnt is loaded with SETTLE−1 and the state moves to EXEC.
- EXEC:
  - If cnt==0: rsp_data is loaded from dp_fout, rsp_valid is set, and the state moves to RESP.
  - Otherwise cnt is decremented.
- RESP: on rsp_valid & rsp_ready, rsp_valid clears and the state moves to IDLE. No request is accepted in the same cycle.
- dp_a, dp_b and dp_op are held unchanged from accept until the next accept. dp_fout is sampled only at the capture edge.
- A requester may drop valid before it is accepted; nothing is recorded in that case. Request inputs are ignored outside IDLE.
- cnt is 4 bits wide. SETTLE values outside 1..15 are unsupported.

## Timing
- Reset values: req0_ready=0, req1_ready=0, dp_a=0, dp_b=0, dp_op=0, dp_cin=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, cnt=0, last_id=1.
- Latency: rsp_valid rises exactly SETTLE clock edges after the accept edge.
- Minimum issue interval is SETTLE+2 cycles with rsp_ready held high: accept, SETTLE EXEC cycles, one RESP handshake cycle, then the next accept from IDLE.
- Backpressure: while rsp_ready is low in RESP, rsp_valid, rsp_data and rsp_id stay stable, both ready outputs stay 0, and busy stays 1.
- Reset asserted in any state: all outputs go to their reset values immediately (asynchronous). Any in-flight operation is discarded and no response is produced. After rst_n deasserts, the first accept is possible on the first rising edge.

## Test plan
- Single request, SETTLE=2, adder attached: req0 with A=0x40000000, B=0x3F800000, op=0.
  - req0_ready is high in the accept cycle.
  - rsp_valid rises 2 edges later with rsp_data=0x40400000 and rsp_id=0.
- Subtract from requester 1: A=0x40400000, B=0x3F800000, op=1.
  - dp_op=1 is held through EXEC and RESP.
  - Response is rsp_data=0x40000000 with rsp_id=1.
- Both requesters valid continuously with rsp_ready=1:
  - Grant order after reset is 0,1,0,1.
  - Accepts are spaced exactly SETTLE+2 cycles apart.
  - Ready is never high for both requesters at once.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid=1 and rsp_data are stable; both ready outputs are 0.
  - Raising rsp_ready gives IDLE on the next cycle.
- Reset mid-EXEC with SETTLE=4: pull rst_n low in the 2nd EXEC cycle.
  - All outputs read 0 immediately and no rsp_valid appears.
  - After release, a tie grants requester 0 first.
- Parameter sweep SETTLE=1 and SETTLE=15: rsp_valid appears exactly 1 and 15 edges after accept respectively, with correct results.

Source files
------------

// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched
// Sequences operations from two requesters onto a shared combinational
// single-precision add/subtract datapath. The arbiter is round-robin. The
// operands are held stable on the datapath for SETTLE cycles. The result
// is then captured and returned on a valid/ready response channel, tagged
// with the ID of the requester that issued the operation.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b (N=0,1) operation request handshakes
//   dp_a, dp_b, dp_op, dp_cin       registered datapath inputs (cin tied 0)
//   dp_fout                         datapath result
//   rsp_valid/ready/data/id         response handshake
//   busy                            high whenever the sequencer is not idle
module fp_addsub_sched #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    output logic        dp_op,
    output logic        dp_cin,
    input  logic [31:0] dp_fout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic        busy
);

    localparam logic [1:0] IDLE_ST = 2'd0;
    localparam logic [1:0] EXEC_ST = 2'd1;
    localparam logic [1:0] RESP_ST = 2'd2;

    // The settle count is loaded as SETTLE-1 so that the capture happens on
    // exactly the SETTLE-th edge after the accept edge.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0]  state_r;
    logic [3:0]  cnt_r;
    logic        last_id_r;
    logic [31:0] dp_a_r;
    logic [31:0] dp_b_r;
    logic        dp_op_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_data_r;
    logic        rsp_id_r;

    logic        idle_s;
    logic        grant1_s;
    logic        accept0_s;
    logic        accept1_s;

    assign idle_s = (state_r == IDLE_ST);

    // Round-robin grant: a lone requester wins; on a tie the requester that
    // was not served last wins.
    always_comb begin
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant1_s = ~last_id_r;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant1_s = 1'b0;
        end
    end

    // Ready is gated by rst_n so that it drops the instant reset asserts.
    assign req0_ready = idle_s & req0_valid & ~grant1_s & rst_n;
    assign req1_ready = idle_s & req1_valid &  grant1_s & rst_n;
    assign accept0_s  = req0_valid & req0_ready;
    assign accept1_s  = req1_valid & req1_ready;

    // Sequencer: accept in IDLE, count down the settle time in EXEC,
    // hold the response in RESP until it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE_ST;
            cnt_r       <= 4'd0;
            last_id_r   <= 1'b1;
            dp_a_r      <= 32'd0;
            dp_b_r      <= 32'd0;
            dp_op_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            rsp_id_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE_ST: begin
                    if (accept0_s) begin
                        dp_a_r    <= req0_a;
                        dp_b_r    <= req0_b;
                        dp_op_r   <= req0_op;
                        rsp_id_r  <= 1'b0;
                        last_id_r <= 1'b0;
                        cnt_r     <= CNT_LOAD;
                        state_r   <= EXEC_ST;
                    end else if (accept1_s) begin
                        dp_a_r    <= req1_a;
                        dp_b_r    <= req1_b;
                        dp_op_r   <= req1_op;
                        rsp_id_r  <= 1'b1;
                        last_id_r <= 1'b1;
                        cnt_r     <= CNT_LOAD;
                        state_r   <= EXEC_ST;
                    end else begin
                        state_r   <= IDLE_ST;
                    end
                end
                EXEC_ST: begin
                    if (cnt_r == 4'd0) begin
                        rsp_data_r  <= dp_fout;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP_ST;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP_ST: begin
                    if (rsp_valid_r && rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE_ST;
                    end else begin
                        state_r     <= RESP_ST;
                    end
                end
                default: begin
                    state_r     <= IDLE_ST;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign dp_a      = dp_a_r;
    assign dp_b      = dp_b_r;
    assign dp_op     = dp_op_r;
    assign dp_cin    = 1'b0;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = ~idle_s;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Testbench for fp_addsub_sched. Four instances with SETTLE = 2, 4, 1 and 15
// share clock, reset and request inputs. Each instance drives its own table
// based add/sub model. Every scenario starts from a fresh reset, so the
// instances stay aligned. Each scenario then checks the instance that
// matches it.
module tb_fp_addsub_sched;

    function automatic int st(input int g);
        return (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 15;
    endfunction

    // Hand-computed IEEE-754 results for the operand pairs used below.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if      (a == 32'h40000000 && b == 32'h3F800000 && op == 1'b0) return 32'h40400000; // 2+1=3
        else if (a == 32'h40400000 && b == 32'h3F800000 && op == 1'b1) return 32'h40000000; // 3-1=2
        else if (a == 32'h3F800000 && b == 32'h3F800000 && op == 1'b0) return 32'h40000000; // 1+1=2
        else if (a == 32'h40800000 && b == 32'h3F800000 && op == 1'b1) return 32'h40400000; // 4-1=3
        else if (a == 32'h40A00000 && b == 32'h40400000 && op == 1'b0) return 32'h41000000; // 5+3=8
        else return 32'h7FC00000;
    endfunction

    logic clk;
    logic rst_n;
    logic req0_valid, req0_op, req1_valid, req1_op, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;

    logic        r0_rdy [4];
    logic        r1_rdy [4];
    logic [31:0] dpa    [4];
    logic [31:0] dpb    [4];
    logic        dpop   [4];
    logic        dpcin  [4];
    logic [31:0] fout   [4];
    logic        rv     [4];
    logic [31:0] rdata  [4];
    logic        rid    [4];
    logic        bsy    [4];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign fout[g] = fp_model(dpa[g], dpb[g], dpop[g]);
        fp_addsub_sched #(.SETTLE(st(g))) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(req0_valid), .req0_ready(r0_rdy[g]), .req0_op(req0_op),
            .req0_a(req0_a), .req0_b(req0_b),
            .req1_valid(req1_valid), .req1_ready(r1_rdy[g]), .req1_op(req1_op),
            .req1_a(req1_a), .req1_b(req1_b),
            .dp_a(dpa[g]), .dp_b(dpb[g]), .dp_op(dpop[g]), .dp_cin(dpcin[g]),
            .dp_fout(fout[g]),
            .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_data(rdata[g]),
            .rsp_id(rid[g]), .busy(bsy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_op = 1'b0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_a = 32'd0; req1_b = 32'd0;
        rsp_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        for (int g = 0; g < 4; g++) begin
            total++;
            if ({r0_rdy[g], r1_rdy[g], dpa[g], dpb[g], dpop[g], dpcin[g], rv[g], rdata[g], rid[g], bsy[g]} !== 103'd0) begin
                bad++;
                $display("FAIL reset_values inst%0d: got %h want 0", g,
                    {r0_rdy[g], r1_rdy[g], dpa[g], dpb[g], dpop[g], dpcin[g], rv[g], rdata[g], rid[g], bsy[g]});
            end
        end
    endtask

    // One request on instance g, exact-latency check, then handshake.
    task automatic test_single(input int g, input logic id, input logic op,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        apply_reset();
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        total++;
        if ({r0_rdy[g], r1_rdy[g]} !== {~id, id}) begin
            bad++;
            $display("FAIL single_ready inst%0d: got %b want %b", g, {r0_rdy[g], r1_rdy[g]}, {~id, id});
        end
        tick();
        clear_inputs();
        for (int k = 1; k <= st(g); k++) begin
            total++;
            if (dpop[g] !== op || bsy[g] !== 1'b1) begin
                bad++;
                $display("FAIL single_exec_hold inst%0d k=%0d: got op=%b busy=%b want op=%b busy=1", g, k, dpop[g], bsy[g], op);
            end
            tick();
            total++;
            if (rv[g] !== (k == st(g))) begin
                bad++;
                $display("FAIL single_latency inst%0d edge=%0d: got rsp_valid=%b want %b", g, k, rv[g], (k == st(g)));
            end
        end
        total++;
        if (rdata[g] !== exp || rid[g] !== id || dpop[g] !== op) begin
            bad++;
            $display("FAIL single_result inst%0d: got data=%h id=%b op=%b want data=%h id=%b op=%b",
                g, rdata[g], rid[g], dpop[g], exp, id, op);
        end
        rsp_ready = 1'b1;
        tick();
        total++;
        if (rv[g] !== 1'b0 || bsy[g] !== 1'b0) begin
            bad++;
            $display("FAIL single_release inst%0d: got valid=%b busy=%b want 0 0", g, rv[g], bsy[g]);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int gid [8];
        int gcyc [8];
        int n = 0;
        apply_reset();
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h40000000; req0_b = 32'h3F800000;
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'h40400000; req1_b = 32'h3F800000;
        rsp_ready  = 1'b1;
        #1;
        for (int c = 0; c < 18; c++) begin
            total++;
            if (r0_rdy[0] === 1'b1 && r1_rdy[0] === 1'b1) begin
                bad++;
                $display("FAIL rr_both_ready cycle=%0d: got 11 want at most one", c);
            end
            if (n < 8 && r0_rdy[0] === 1'b1) begin gid[n] = 0; gcyc[n] = c; n++; end
            if (n < 8 && r1_rdy[0] === 1'b1) begin gid[n] = 1; gcyc[n] = c; n++; end
            if (rv[0] === 1'b1) begin
                total++;
                if (rdata[0] !== ((rid[0] === 1'b1) ? 32'h40000000 : 32'h40400000)) begin
                    bad++;
                    $display("FAIL rr_result cycle=%0d id=%b: got %h", c, rid[0], rdata[0]);
                end
            end
            tick();
        end
        clear_inputs();
        total++;
        if (n < 4) begin
            bad++;
            $display("FAIL rr_grant_count: got %0d want >=4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (gid[i] != (i % 2) || gcyc[i] != i * (st(0) + 2)) begin
                    bad++;
                    $display("FAIL rr_order grant%0d: got id=%0d cycle=%0d want id=%0d cycle=%0d",
                        i, gid[i], gcyc[i], i % 2, i * (st(0) + 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h40000000; req0_b = 32'h3F800000;
        tick();
        req0_valid = 1'b0;
        repeat (st(0)) tick();
        // Both requesters knock while the response is blocked.
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_op = 1'b1; req1_a = 32'h40400000; req1_b = 32'h3F800000;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (rv[0] !== 1'b1 || rdata[0] !== 32'h40400000 || rid[0] !== 1'b0 ||
                r0_rdy[0] !== 1'b0 || r1_rdy[0] !== 1'b0 || bsy[0] !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold k=%0d: got v=%b d=%h id=%b rdy=%b%b busy=%b want 1 40400000 0 00 1",
                    k, rv[0], rdata[0], rid[0], r0_rdy[0], r1_rdy[0], bsy[0]);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (r0_rdy[0] !== 1'b0 || r1_rdy[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_handshake_ready: got %b%b want 00", r0_rdy[0], r1_rdy[0]);
        end
        tick();
        rsp_ready = 1'b0;
        total++;
        if (bsy[0] !== 1'b0 || rv[0] !== 1'b0 || r1_rdy[0] !== 1'b1 || r0_rdy[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got busy=%b v=%b rdy=%b%b want 0 0 01", bsy[0], rv[0], r0_rdy[0], r1_rdy[0]);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_exec();
        apply_reset();
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h40000000; req0_b = 32'h3F800000;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({r0_rdy[1], r1_rdy[1], dpa[1], dpb[1], dpop[1], dpcin[1], rv[1], rdata[1], rid[1], bsy[1]} !== 103'd0) begin
            bad++;
            $display("FAIL midreset_values: got %h want 0",
                {r0_rdy[1], r1_rdy[1], dpa[1], dpb[1], dpop[1], dpcin[1], rv[1], rdata[1], rid[1], bsy[1]});
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (rv[1] !== 1'b0 || bsy[1] !== 1'b0) begin
                bad++;
                $display("FAIL midreset_no_rsp k=%0d: got v=%b busy=%b want 0 0", k, rv[1], bsy[1]);
            end
        end
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'h40400000; req1_b = 32'h3F800000;
        rst_n = 1'b1;
        #1;
        total++;
        if (r0_rdy[1] !== 1'b1 || r1_rdy[1] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_tie: got rdy=%b%b want 10", r0_rdy[1], r1_rdy[1]);
        end
        tick();
        clear_inputs();
        for (int k = 1; k <= st(1); k++) begin
            tick();
            total++;
            if (rv[1] !== (k == st(1))) begin
                bad++;
                $display("FAIL midreset_latency edge=%0d: got %b want %b", k, rv[1], (k == st(1)));
            end
        end
        total++;
        if (rdata[1] !== 32'h40400000 || rid[1] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_result: got %h id=%b want 40400000 id=0", rdata[1], rid[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single(0, 1'b0, 1'b0, 32'h40000000, 32'h3F800000, 32'h40400000);
        test_single(0, 1'b1, 1'b1, 32'h40400000, 32'h3F800000, 32'h40000000);
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
        test_single(2, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000);
        test_single(3, 1'b1, 1'b1, 32'h40800000, 32'h3F800000, 32'h40400000);
        test_single(1, 1'b1, 1'b0, 32'h40A00000, 32'h40400000, 32'h41000000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
